decode_exec_issue_arbiter: RTL and testbench



---
 rtl/decode_exec_issue_arbiter.sv | 108 ++++++++++
 tb/tb_decode_exec_issue_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/decode_exec_issue_arbiter.sv
// Round-robin arbiter sharing the single decode-to-execute issue slot among NUM_REQ lanes.
// The winning packet is latched into a one-deep slot that execute drains with recv.
module decode_exec_issue_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PKT_W   = 256,
  parameter int unsigned SRC_W   = $clog2(NUM_REQ),
  parameter int unsigned CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*PKT_W-1:0] req_pkt,
  output logic [NUM_REQ-1:0]       req_grant,
  output logic                     is_busy,
  output logic [PKT_W-1:0]         data,
  output logic [SRC_W-1:0]         data_src,
  input  logic                     recv,
  input  logic                     flush,
  output logic [CNT_W-1:0]         stall_cycles
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic               busy_q,   busy_d;
  logic [PKT_W-1:0]   data_q,   data_d;
  logic [SRC_W-1:0]   src_q,    src_d;
  logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   stall_q,  stall_d;

  logic               slot_free_c;
  logic               grant_any_c;
  logic [SRC_W-1:0]   winner_c;
  logic [SRC_W-1:0]   idx_c;
  logic [NUM_REQ-1:0] grant_c;

  // Round-robin scan starting at rr_ptr; grants only into a free, unflushed slot.
  always_comb begin
    grant_c     = '0;
    winner_c    = '0;
    idx_c       = '0;
    grant_any_c = 1'b0;
    slot_free_c = !busy_q || recv;
    if (!reset && slot_free_c && !flush) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        idx_c = rr_ptr_q + SRC_W'(k);
        if (!grant_any_c && req_valid[idx_c]) begin
          grant_any_c = 1'b1;
          winner_c    = idx_c;
        end
      end
    end
    if (grant_any_c) begin
      grant_c[winner_c] = 1'b1;
    end
  end

  // Slot, pointer and stall-counter next state; flush outranks both grant and recv.
  always_comb begin
    busy_d   = busy_q;
    data_d   = data_q;
    src_d    = src_q;
    rr_ptr_d = rr_ptr_q;
    stall_d  = stall_q;
    if (flush) begin
      busy_d = 1'b0;
    end else if (grant_any_c) begin
      busy_d   = 1'b1;
      data_d   = req_pkt[32'(winner_c) * PKT_W +: PKT_W];
      src_d    = winner_c;
      rr_ptr_d = winner_c + SRC_W'(1);
    end else if (recv) begin
      busy_d = 1'b0;
    end
    if ((|req_valid) && !grant_any_c && !flush && (stall_q != CNT_MAX)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q   <= 1'b0;
      data_q   <= '0;
      src_q    <= '0;
      rr_ptr_q <= '0;
      stall_q  <= '0;
    end else begin
      busy_q   <= busy_d;
      data_q   <= data_d;
      src_q    <= src_d;
      rr_ptr_q <= rr_ptr_d;
      stall_q  <= stall_d;
    end
  end

  assign req_grant    = grant_c;
  assign is_busy      = busy_q;
  assign data         = data_q;
  assign data_src     = src_q;
  assign stall_cycles = stall_q;

  a_grant_onehot : assert property (@(posedge clk) disable iff (reset) $onehot0(req_grant))
    else $error("req_grant has more than one bit set");

  // Consuming an empty slot is harmless to the hardware but points at an execute-side bug.
  a_recv_empty : assert property (@(posedge clk) disable iff (reset) recv |-> is_busy)
    else $warning("recv asserted while the issue slot is empty");

endmodule

// File: tb/tb_decode_exec_issue_arbiter.sv
// Directed bench for decode_exec_issue_arbiter with a per-cycle reference model check.
module tb_decode_exec_issue_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned PKT_W   = 256;
  localparam int unsigned SRC_W   = 2;
  localparam int unsigned CNT_W   = 4;
  localparam int          SAT     = 15;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*PKT_W-1:0] req_pkt;
  logic [NUM_REQ-1:0]       req_grant;
  logic                     is_busy;
  logic [PKT_W-1:0]         data;
  logic [SRC_W-1:0]         data_src;
  logic                     recv;
  logic                     flush;
  logic [CNT_W-1:0]         stall_cycles;

  int n_tests = 0;
  int n_fail  = 0;

  decode_exec_issue_arbiter #(
    .NUM_REQ(NUM_REQ), .PKT_W(PKT_W), .SRC_W(SRC_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_pkt(req_pkt),
    .req_grant(req_grant), .is_busy(is_busy), .data(data), .data_src(data_src),
    .recv(recv), .flush(flush), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic logic [PKT_W-1:0] pkt_of(input int i);
    case (i)
      0:       return {4{64'h0123_4567_89AB_CDEF}};
      1:       return {8{32'h1111_0001}};
      2:       return 256'hA5;
      default: return {2{128'hC0DE_3333_0000_FFFF_5A5A_A5A5_7777_3333}};
    endcase
  endfunction

  task automatic chk(input string name, input logic [PKT_W-1:0] act, input logic [PKT_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: slot contents, round-robin pointer and stall count as plain integers.
  logic             m_busy  = 1'b0;
  logic [PKT_W-1:0] m_data  = '0;
  int               m_src   = 0;
  int               m_ptr   = 0;
  int               m_stall = 0;
  int               mw;
  logic [NUM_REQ-1:0] m_grant;

  // Inputs change just after posedge, so the falling edge sees settled values for the coming edge.
  always @(negedge clk) begin
    mw = -1;
    if (!reset && (!m_busy || recv) && !flush) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (mw < 0 && req_valid[(m_ptr + k) % NUM_REQ]) mw = (m_ptr + k) % NUM_REQ;
      end
    end
    m_grant = '0;
    if (mw >= 0) m_grant[mw] = 1'b1;

    chk("model_grant", req_grant, m_grant);
    chk("model_busy", is_busy, m_busy);
    chk("model_stall", stall_cycles, m_stall);
    if (m_busy) begin
      chk("model_data", data, m_data);
      chk("model_src", data_src, m_src);
    end

    if (reset) begin
      m_busy = 1'b0; m_data = '0; m_src = 0; m_ptr = 0; m_stall = 0;
    end else begin
      if (req_valid != 0 && mw < 0 && !flush && m_stall < SAT) m_stall++;
      if (flush) begin
        m_busy = 1'b0;
      end else if (mw >= 0) begin
        m_busy = 1'b1;
        m_data = pkt_of(mw);
        m_src  = mw;
        m_ptr  = (mw + 1) % NUM_REQ;
      end else if (recv) begin
        m_busy = 1'b0;
      end
    end
  end

  logic [NUM_REQ-1:0] exp_g;

  initial begin
    reset     = 1'b1;
    req_valid = 4'hF;
    recv      = 1'b0;
    flush     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) req_pkt[i*PKT_W +: PKT_W] = pkt_of(i);

    // Reset: no grant even with every lane requesting, then idle.
    #1 chk("grant_in_reset", req_grant, 4'b0000);
    step(); step();
    chk("grant_in_reset2", req_grant, 4'b0000);
    reset = 1'b0; req_valid = 4'h0;
    repeat (5) step();
    chk("idle_busy", is_busy, 1'b0);
    chk("idle_grant", req_grant, 4'b0000);
    chk("idle_stall", stall_cycles, 4'd0);

    // Single lane 2, drained one cycle after it lands.
    req_valid = 4'b0100;
    #1 chk("lane2_grant", req_grant, 4'b0100);
    step(); req_valid = 4'b0000;
    chk("lane2_busy", is_busy, 1'b1);
    chk("lane2_data", data, 256'hA5);
    chk("lane2_src", data_src, 2'd2);
    step(); recv = 1'b1;
    chk("lane2_busy_c2", is_busy, 1'b1);
    step(); recv = 1'b0;
    chk("lane2_drained", is_busy, 1'b0);
    chk("lane2_data_hold", data, 256'hA5);

    // All lanes, back-to-back with recv every cycle: 0,1,2,3,0,1.
    reset = 1'b1; step(); reset = 1'b0;
    req_valid = 4'hF;
    for (int k = 0; k < 6; k++) begin
      exp_g = 4'(1 << (k % 4));
      #1 chk("rr_grant", req_grant, exp_g);
      if (k > 0) chk("rr_busy", is_busy, 1'b1);
      step(); recv = 1'b1;
    end
    req_valid = 4'h0;
    chk("rr_data_last", data, pkt_of(1));
    chk("rr_stall", stall_cycles, 4'd0);
    step(); recv = 1'b0;
    chk("rr_drained", is_busy, 1'b0);

    // Slot held full for 3 cycles while lane 1 waits.
    req_valid = 4'b0001;
    #1 chk("fill_lane0", req_grant, 4'b0001);
    step(); req_valid = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      #1 chk("blocked_grant", req_grant, 4'b0000);
      step();
    end
    chk("blocked_stall", stall_cycles, 4'd3);
    recv = 1'b1;
    #1 chk("replace_grant", req_grant, 4'b0010);
    step(); recv = 1'b0; req_valid = 4'h0;
    chk("replace_busy", is_busy, 1'b1);
    chk("replace_src", data_src, 2'd1);
    chk("replace_data", data, pkt_of(1));

    // Flush with lanes 0 and 3 waiting; pointer sits at 2 so lane 3 wins afterwards.
    req_valid = 4'b1001; flush = 1'b1;
    #1 chk("flush_grant", req_grant, 4'b0000);
    step(); flush = 1'b0;
    chk("flush_busy", is_busy, 1'b0);
    #1 chk("post_flush_grant", req_grant, 4'b1000);
    step(); req_valid = 4'h0;
    chk("post_flush_src", data_src, 2'd3);
    chk("flush_stall", stall_cycles, 4'd3);
    recv = 1'b1; step(); recv = 1'b0;

    // Lane 0 blocked 20 cycles: counter saturates at 15.
    req_valid = 4'b0001;
    step();
    repeat (20) step();
    chk("stall_sat", stall_cycles, 4'd15);
    req_valid = 4'h0; recv = 1'b1;
    step(); recv = 1'b0;
    chk("sat_drained", is_busy, 1'b0);
    recv = 1'b1;
    step(); recv = 1'b0;
    chk("recv_empty_busy", is_busy, 1'b0);
    chk("recv_empty_data", data, pkt_of(0));
    chk("stall_sat_hold", stall_cycles, 4'd15);

    // Reset in the middle of traffic drops everything.
    req_valid = 4'hF;
    step();
    reset = 1'b1; recv = 1'b1;
    #1 chk("reset_mid_grant", req_grant, 4'b0000);
    step(); reset = 1'b0; recv = 1'b0; req_valid = 4'b1010;
    chk("reset_mid_busy", is_busy, 1'b0);
    chk("reset_mid_data", data, 256'h0);
    chk("reset_mid_src", data_src, 2'd0);
    chk("reset_mid_stall", stall_cycles, 4'd0);
    #1 chk("reset_ptr_grant", req_grant, 4'b0010);
    step(); req_valid = 4'h0;
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
